pixel_point_op: RTL

- Streaming per-pixel point-operation unit for the image downsampling datapath.
- Parametrised successor of the fixed 8-bit combinational inverter.
- Four runtime-selectable modes: pass, invert, threshold, saturating brightness offset.
- Two-stage pipeline with valid/ready handshake; counts pixels per frame, flags the last pixel and pulses on frame completion.

---
 rtl/pixel_pkg.sv | 16 +
 rtl/pixel_op_alu.sv | 35 +++
 rtl/pixel_point_op.sv | 139 +++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel point-operation datapath: operation modes
// and default geometry of the 200x200 test image.
package pixel_pkg;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_FRAME_PIXELS = 40000;
    localparam int DEF_CNT_W        = 16;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_THR  = 2'd2,
        MODE_OFS  = 2'd3
    } mode_e;

endpackage

// File: rtl/pixel_op_alu.sv
// Combinational per-pixel operation: pass, invert, threshold or saturating
// signed offset.
module pixel_op_alu
    import pixel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] param,
    input  logic [DATA_W-1:0] pix,
    output logic [DATA_W-1:0] result
);

    localparam logic [DATA_W-1:0] MAX = '1;

    // Two guard bits: top bit is the sign, next one flags overflow above MAX.
    logic [DATA_W+1:0] sum;

    always_comb begin
        sum    = {2'b00, pix} + {{2{param[DATA_W-1]}}, param};
        result = pix;
        case (mode_e'(mode))
            MODE_PASS: result = pix;
            MODE_INV:  result = ~pix;
            MODE_THR:  result = (pix >= param) ? MAX : '0;
            MODE_OFS: begin
                if (sum[DATA_W+1])   result = '0;
                else if (sum[DATA_W]) result = MAX;
                else                  result = sum[DATA_W-1:0];
            end
            default:   result = pix;
        endcase
    end

endmodule

// File: rtl/pixel_point_op.sv
// Two-stage streaming point-operation unit with valid/ready handshake,
// per-frame mode latch and frame pixel counting.
module pixel_point_op
    import pixel_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] param_i,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    logic [CNT_W-1:0]  in_cnt_q, in_cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] param_q, param_d;

    logic              s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0] s1_pix_q, s1_pix_d;
    logic              s1_last_q, s1_last_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [DATA_W-1:0] s1_param_q, s1_param_d;

    logic              s2_vld_q, s2_vld_d;
    logic [DATA_W-1:0] s2_pix_q, s2_pix_d;
    logic              s2_last_q, s2_last_d;
    logic              frame_done_q, frame_done_d;

    logic              s2_load, s1_adv, in_xfer, out_xfer, first_pix;
    logic [1:0]        cur_mode;
    logic [DATA_W-1:0] cur_param, alu_res;

    assign s2_load   = !s2_vld_q || out_ready;
    assign s1_adv    = s1_vld_q && s2_load;
    assign in_ready  = !s1_vld_q || s2_load;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = s2_vld_q && out_ready;
    assign first_pix = (in_cnt_q == '0);

    // The first pixel of a frame uses the live inputs, later ones the latch.
    assign cur_mode  = first_pix ? mode_i  : mode_q;
    assign cur_param = first_pix ? param_i : param_q;

    pixel_op_alu #(.DATA_W(DATA_W)) u_alu (
        .mode   (s1_mode_q),
        .param  (s1_param_q),
        .pix    (s1_pix_q),
        .result (alu_res)
    );

    always_comb begin
        in_cnt_d     = in_cnt_q;
        mode_d       = mode_q;
        param_d      = param_q;
        s1_vld_d     = s1_vld_q;
        s1_pix_d     = s1_pix_q;
        s1_last_d    = s1_last_q;
        s1_mode_d    = s1_mode_q;
        s1_param_d   = s1_param_q;
        s2_vld_d     = s2_vld_q;
        s2_pix_d     = s2_pix_q;
        s2_last_d    = s2_last_q;
        frame_done_d = out_xfer && s2_last_q;

        if (in_xfer) begin
            in_cnt_d = (in_cnt_q == LAST_IDX) ? '0 : in_cnt_q + 1'b1;
            if (first_pix) begin
                mode_d  = mode_i;
                param_d = param_i;
            end
        end

        if (in_ready) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_pix_d   = in_data;
                s1_last_d  = (in_cnt_q == LAST_IDX);
                s1_mode_d  = cur_mode;
                s1_param_d = cur_param;
            end
        end

        if (s2_load) s2_vld_d = s1_vld_q;
        if (s1_adv) begin
            s2_pix_d  = alu_res;
            s2_last_d = s1_last_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt_q     <= '0;
            mode_q       <= '0;
            param_q      <= '0;
            s1_vld_q     <= 1'b0;
            s1_pix_q     <= '0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= '0;
            s1_param_q   <= '0;
            s2_vld_q     <= 1'b0;
            s2_pix_q     <= '0;
            s2_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            in_cnt_q     <= in_cnt_d;
            mode_q       <= mode_d;
            param_q      <= param_d;
            s1_vld_q     <= s1_vld_d;
            s1_pix_q     <= s1_pix_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s1_param_q   <= s1_param_d;
            s2_vld_q     <= s2_vld_d;
            s2_pix_q     <= s2_pix_d;
            s2_last_q    <= s2_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_valid  = s2_vld_q;
    assign out_data   = s2_pix_q;
    assign out_last   = s2_vld_q && s2_last_q;
    assign frame_done = frame_done_q;
    assign busy       = (in_cnt_q != '0) || s1_vld_q || s2_vld_q;

endmodule
